instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Instruction fetch stage of the MIPS datapath, directly upstream of the control unit.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Captures returned instructions into the IF/ID register; its op_code output (instr[31:26]) drives the control unit.
- Applies branch/jump redirects from decode, plus stall and flush from the hazard logic.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned)
TIMEOUT_CYC, 255, ack watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  request address, word aligned
imem_ack  input  1  one-cycle pulse: imem_rdata valid
imem_rdata  input  32  instruction word
stall  input  1  hold IF/ID and PC (hazard unit)
flush  input  1  invalidate IF/ID contents
branch_taken  input  1  decode resolved a taken beq
branch_target  input  ADDR_W  branch destination
jump  input  1  decode holds a j instruction
jump_target  input  ADDR_W  jump destination
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  32  IF/ID instruction (NOP when invalid)
if_id_pc4  output  ADDR_W  PC+4 of that instruction
op_code  output  6  if_id_instr[31:26], to control unit
fetch_err  output  1  sticky watchdog error

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Reset values:
- pc=RESET_PC; req_addr=RESET_PC.
- imem_req=0; if_id_valid=0; if_id_instr=32'h0; if_id_pc4=0; fetch_err=0.
- state=S_START.

Memory protocol:
- imem_req high, imem_addr=req_addr; both held stable until the imem_ack cycle.
- imem_req may drop in the cycle after an ack.
- Acks arriving while imem_req=0 are ignored.

Redirect:
- redirect = jump | branch_taken; jump has priority when both are high.
- Target low 2 bits are forced to 0.

States:
- S_START: one cycle after reset release → S_REQ.
- S_REQ: imem_req=1, req_addr=pc.
  - On ack with no redirect and stall=0: IF/ID ← {1, rdata, pc+4}; pc ← pc+4; stay in S_REQ (back-to-back fetch).
  - On ack with stall=1: rdata goes to the hold buffer → S_HOLD.
  - On ack with redirect in the same cycle: rdata discarded; pc ← target; IF/ID cleared; stay in S_REQ.
  - On redirect without ack: pc ← target; IF/ID cleared → S_DROP.
- S_HOLD: imem_req=0.
  - When stall=0: IF/ID ← buffer; pc ← pc+4 → S_REQ.
  - On redirect: buffer discarded; pc ← target → S_REQ.
- S_DROP: imem_req=1 at the old req_addr until ack; data discarded → S_REQ at the new pc.
  - A further redirect in S_DROP overwrites pc only.

Stall:
- IF/ID and pc hold; a request already issued still completes.

Flush and redirect on IF/ID:
- flush or redirect sets if_id_valid=0 and if_id_instr=0 next cycle.
- Both override stall.

Arithmetic:
- pc+4 wraps modulo 2^ADDR_W; no overflow flag.

Latency:
- Minimum 1 cycle from ack to if_id_valid.
- Throughput is one instruction per cycle with a zero-wait memory.

Reset mid-operation:
- Immediate return to reset values; any outstanding request is abandoned.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter runs while imem_req=1 and no ack.
  - On reaching TIMEOUT_CYC: fetch_err set (sticky until reset), imem_req dropped, state → S_HOLD-like idle.
  - Fetching stops in that idle state.
- Undefined: no counter; fetch_err tied 0; waits indefinitely.

Decomposition:
Package fetch_pkg:
- State encodings S_START/S_REQ/S_HOLD/S_DROP.
- NOP_INSTR=32'h0.
- OPCODE_MSB=31, OPCODE_LSB=26.
- PC_INC=4.

Sub-module if_id_reg:
- Holds valid/instr/pc4 with load, stall and clear inputs.
- Reused by the later pipeline version.

Test Plan:
- Reset, RESET_PC=0, zero-wait ack → imem_addr 0,4,8; if_id_pc4 4,8,12; op_code = rdata[31:26] one cycle after each ack.
- stall=1 for 3 cycles during an ack of 32'h8C08_0004 → S_HOLD, imem_req=0; IF/ID unchanged; after stall drops, if_id_instr=32'h8C08_0004 and pc=+4.
- jump=1, jump_target=32'h0000_0103 while a request at 0x10 is pending → address 0x10 held until ack and discarded; next request at 0x100; if_id_valid=0 in between.
- branch_taken and ack in the same cycle, branch_target=0x40 → rdata dropped; next imem_addr=0x40.
- pc=32'hFFFF_FFFC, ack → pc wraps to 0, if_id_pc4=0; rst_n low mid-request → imem_req=0 and pc=RESET_PC without a clock edge.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=8, no ack → fetch_err=1 after 8 cycles, imem_req=0, stays 1 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose: state encoding of the fetch controller, NOP word, opcode field
//          position and the PC increment used by fetch and IF/ID.
// Ports:   none (package)
package fetch_pkg;

    // S_ERR is only reachable when the ack watchdog is built in.
    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int          PC_INC     = 4;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, stall and clear
// Purpose: holds the fetched instruction, its PC+4 and a valid flag.
//          clear has priority over everything; stall blocks a load.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load, stall, clear  register controls
//   next_instr          instruction word to capture
//   next_pc4            PC+4 of that instruction
//   valid, instr, pc4   registered contents (instr is NOP when invalid)
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              stall,
    input  logic              clear,
    input  logic [31:0]       next_instr,
    input  logic [ADDR_W-1:0] next_pc4,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (clear) begin
            // pc4 is left alone; it is meaningless while valid is low
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load && !stall) begin
            valid <= 1'b1;
            instr <= next_instr;
            pc4   <= next_pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS instruction fetch stage with IF/ID register
// Purpose: keeps the PC, issues word reads over a req/ack handshake,
//          captures returned words into IF/ID and applies redirects,
//          stall and flush. Optional macro FETCH_TIMEOUT_EN builds an
//          ack watchdog that raises a sticky fetch_err and stops fetching.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req, imem_addr           read request and word address
//   imem_ack, imem_rdata          one-cycle ack with instruction word
//   stall, flush                  hazard unit controls
//   branch_taken, branch_target   taken beq redirect from decode
//   jump, jump_target             j redirect from decode (wins over branch)
//   if_id_valid/instr/pc4         IF/ID register contents
//   op_code                       if_id_instr[31:26] to the control unit
//   fetch_err                     sticky watchdog error
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [5:0]        op_code,
    output logic              fetch_err
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       buf_q, buf_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              kill;
    logic              ld;
    logic [31:0]       ld_instr;
    logic              clr;
    logic              to_hit;

    assign redirect = jump | branch_taken;
    assign target   = (jump ? jump_target : branch_target) & ~ADDR_W'(3);
    assign pc_inc   = pc_q + ADDR_W'(PC_INC);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // Counts consecutive requesting cycles without an ack; the cycle that
    // would make the count reach TIMEOUT_CYC is the one that trips.
    assign to_hit = imem_req && !imem_ack && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!imem_req || imem_ack || to_hit) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = err_q;
`else
    assign to_hit    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_START;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        ld       = 1'b0;
        ld_instr = imem_rdata;
        kill     = 1'b0;
        case (state_q)
            S_START: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (to_hit) begin
                    state_d = S_ERR;
                end else if (imem_ack) begin
                    if (redirect) begin
                        // returned word is on the wrong path
                        pc_d = target;
                        kill = 1'b1;
                    end else if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        ld   = 1'b1;
                        pc_d = pc_inc;
                    end
                end else if (redirect) begin
                    // outstanding read must still complete; its data is dropped
                    pc_d    = target;
                    kill    = 1'b1;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    kill    = 1'b1;
                    state_d = S_REQ;
                end else if (!stall) begin
                    ld       = 1'b1;
                    ld_instr = buf_q;
                    pc_d     = pc_inc;
                    state_d  = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = target;
                    kill = 1'b1;
                end
                if (to_hit) begin
                    state_d = S_ERR;
                end else if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = (state_q == S_REQ) || (state_q == S_DROP);
        // The address of a discarded read stays on the bus until its ack.
        req_addr_d = (state_d == S_DROP) ? req_addr_q : pc_d;
        // Without a stall, a cycle that delivers nothing leaves a bubble.
        clr = kill || flush || (!stall && !ld);
    end

    assign imem_addr = req_addr_q;

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ld),
        .stall      (stall),
        .clear      (clr),
        .next_instr (ld_instr),
        .next_pc4   (pc_inc),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4)
    );

    assign op_code = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  op_code;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    instr_fetch_stage #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .op_code       (op_code),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        step(); step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
        tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h exp 0", if_id_instr); end
        tests++; if (if_id_pc4 !== 32'h0) begin fails++; $display("FAIL reset_pc4: got %h exp 0", if_id_pc4); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", fetch_err); end
        rst_n = 1'b1;
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL start_req: got req %b addr %h exp 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h2008_0005;
        words[1] = 32'h8C09_0000;
        words[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = words[i];
            step();
            tests++; if (imem_addr !== 32'(4 * (i + 1))) begin
                fails++; $display("FAIL seq_addr%0d: got %h exp %h", i, imem_addr, 32'(4 * (i + 1))); end
            tests++; if (if_id_pc4 !== 32'(4 * (i + 1)) || if_id_valid !== 1'b1) begin
                fails++; $display("FAIL seq_pc4_%0d: got %h/%b exp %h/1", i, if_id_pc4, if_id_valid, 32'(4 * (i + 1))); end
            tests++; if (op_code !== words[i][31:26] || if_id_instr !== words[i]) begin
                fails++; $display("FAIL seq_op%0d: got %h/%h exp %h", i, op_code, if_id_instr, words[i]); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
        step();
        imem_ack = 1'b0;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b exp 0", imem_req); end
        tests++; if (if_id_instr !== 32'h0109_5020 || if_id_pc4 !== 32'hC) begin
            fails++; $display("FAIL stall_hold1: got %h/%h exp 01095020/c", if_id_instr, if_id_pc4); end
        step(); step();
        tests++; if (if_id_instr !== 32'h0109_5020 || imem_req !== 1'b0) begin
            fails++; $display("FAIL stall_hold3: got %h/%b exp 01095020/0", if_id_instr, imem_req); end
        stall = 1'b0;
        step();
        tests++; if (if_id_instr !== 32'h8C08_0004 || if_id_valid !== 1'b1 || op_code !== 6'h23) begin
            fails++; $display("FAIL stall_release: got %h/%b/%h exp 8c080004/1/23", if_id_instr, if_id_valid, op_code); end
        tests++; if (if_id_pc4 !== 32'h10 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
            fails++; $display("FAIL stall_pc: got %h/%h/%b exp 10/10/1", if_id_pc4, imem_addr, imem_req); end
    endtask

    task automatic test_jump();
        jump = 1'b1; jump_target = 32'h0000_0103;
        step();
        jump = 1'b0;
        tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            fails++; $display("FAIL jump_clear: got %b/%h exp 0/0", if_id_valid, if_id_instr); end
        tests++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
            fails++; $display("FAIL jump_hold1: got %h/%b exp 10/1", imem_addr, imem_req); end
        step();
        tests++; if (imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
            fails++; $display("FAIL jump_hold2: got %h/%b exp 10/0", imem_addr, if_id_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        tests++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL jump_new: got %h/%b/%b exp 100/0/1", imem_addr, if_id_valid, imem_req); end
    endtask

    task automatic test_branch_ack();
        branch_taken = 1'b1; branch_target = 32'h40; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0; imem_ack = 1'b0;
        tests++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            fails++; $display("FAIL br_ack: got %h/%b/%h exp 40/0/0", imem_addr, if_id_valid, if_id_instr); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        tests++; if (if_id_instr !== 32'h1234_5678 || if_id_pc4 !== 32'h44 || imem_addr !== 32'h44) begin
            fails++; $display("FAIL br_next: got %h/%h/%h exp 12345678/44/44", if_id_instr, if_id_pc4, imem_addr); end
        // jump wins over branch when both are raised
        jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL jump_prio: got %h exp 200", imem_addr); end
        imem_rdata = 32'hAAAA_AAAA; flush = 1'b1;
        step();
        flush = 1'b0; imem_ack = 1'b0;
        tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            fails++; $display("FAIL flush: got %b/%h exp 0/0", if_id_valid, if_id_instr); end
    endtask

    task automatic test_wrap_and_async_reset();
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0;
        step();
        imem_ack = 1'b0;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0800_0040;
        step();
        tests++; if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0 || if_id_valid !== 1'b1 || op_code !== 6'h02) begin
            fails++; $display("FAIL wrap_pc4: got %h/%h/%b/%h exp 0/0/1/02", if_id_pc4, imem_addr, if_id_valid, op_code); end
        imem_rdata = 32'h0;
        step();
        imem_ack = 1'b0;
        tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
            fails++; $display("FAIL pre_rst: got %h/%b exp 4/1", imem_addr, imem_req); end
        rst_n = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
            fails++; $display("FAIL async_rst: got %b/%h/%b exp 0/0/0", imem_req, imem_addr, if_id_valid); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_timeout();
        imem_ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (7) step();
        tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL to_early: got %b/%b exp 0/1", fetch_err, imem_req); end
        step();
        tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            fails++; $display("FAIL to_trip: got %b/%b exp 1/0", fetch_err, imem_req); end
        repeat (5) step();
        tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            fails++; $display("FAIL to_sticky: got %b/%b exp 1/0", fetch_err, imem_req); end
        rst_n = 1'b0;
        #1;
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_rst: got %b exp 0", fetch_err); end
        rst_n = 1'b1;
`else
        repeat (20) step();
        tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL no_to: got %b/%b/%h exp 0/1/0", fetch_err, imem_req, imem_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_ack();
        test_wrap_and_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
